// File: rtl/wb_host_master_if.sv
// ---------------------------------------------------------------------------
// wb_host_master_if
//   Bundles the command channel, the response channel and the Wishbone
//   classic master-side signals of wb_host_master into one interface.
//
//   Parameters:
//     ADDR_W  address width (command and Wishbone sides)
//     DATA_W  data width; byte-select width is DATA_W/8
//
//   Modports:
//     master  the wb_host_master view (drives cmd_ready, rsp_*, busy, wb_*_out)
//     slave   the environment view (drives cmd_*, rsp_ready, wb_ack_in,
//             wb_data_in)
// ---------------------------------------------------------------------------
interface wb_host_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [SEL_W-1:0]  cmd_sel;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  // Status
  logic              busy;

  // Wishbone classic master side
  logic              wb_cyc_out;
  logic              wb_stb_out;
  logic              wb_we_out;
  logic [SEL_W-1:0]  wb_sel_out;
  logic [ADDR_W-1:0] wb_addr_out;
  logic [DATA_W-1:0] wb_data_out;
  logic              wb_ack_in;
  logic [DATA_W-1:0] wb_data_in;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output busy,
    output wb_cyc_out, wb_stb_out, wb_we_out, wb_sel_out, wb_addr_out,
           wb_data_out,
    input  wb_ack_in, wb_data_in
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  busy,
    input  wb_cyc_out, wb_stb_out, wb_we_out, wb_sel_out, wb_addr_out,
           wb_data_out,
    output wb_ack_in, wb_data_in
  );
endinterface

// File: rtl/wb_host_master.sv
// ---------------------------------------------------------------------------
// wb_host_master
//   Wishbone classic single-transfer master. A command accepted on the
//   valid/ready command channel becomes one Wishbone read or write cycle;
//   its result is returned on the valid/ready response channel. Only one
//   transfer is ever outstanding.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    wb_host_master_if.master: cmd_*, rsp_*, busy, wb_*
//
//   Parameters:
//     ADDR_W          address width
//     DATA_W          data width (byte selects are DATA_W/8 wide)
//     TIMEOUT_CYCLES  BUS-state cycle limit before abort, 1..65535
//
//   Optional feature (macro WB_MASTER_TIMEOUT_EN):
//     defined   - a 16-bit counter aborts a transfer that sees no ACK within
//                 TIMEOUT_CYCLES cycles, answering with rsp_err=1.
//     undefined - no counter; the master waits for ACK indefinitely and
//                 rsp_err is always 0.
// ---------------------------------------------------------------------------
module wb_host_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  wb_host_master_if.master    bus
);

  localparam int SEL_W = DATA_W / 8;

  // Out-of-range limits would silently wrap the 16-bit counter compare.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_host_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic              cyc_q,       cyc_d;
  logic              stb_q,       stb_d;
  logic              we_q,        we_d;
  logic [SEL_W-1:0]  sel_q,       sel_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              busy_q,      busy_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]       tmo_cnt_q,   tmo_cnt_d;
`endif

  // Next-state and next-output decode. Every output is a flop, so the
  // values computed here become visible one edge later. Wishbone address,
  // data, select and WE keep their last values once CYC drops; only CYC and
  // STB qualify the bus.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef WB_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_data;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end

      BUS: begin
        // ACK takes priority over the timeout limit in the same cycle.
        if (bus.wb_ack_in) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_data_d  = we_q ? '0 : bus.wb_data_in;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LIMIT) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Single state register for the FSM and all registered outputs. Reset is
  // synchronous, so a reset mid-transfer drops CYC/STB and discards any
  // pending response at the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  // cmd_ready is decoded from the state register alone, so there is no
  // combinational path from cmd_valid back to cmd_ready.
  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
`ifdef WB_MASTER_TIMEOUT_EN
  assign bus.rsp_err     = rsp_err_q;
`else
  assign bus.rsp_err     = 1'b0;
`endif
  assign bus.busy        = busy_q;
  assign bus.wb_cyc_out  = cyc_q;
  assign bus.wb_stb_out  = stb_q;
  assign bus.wb_we_out   = we_q;
  assign bus.wb_sel_out  = sel_q;
  assign bus.wb_addr_out = addr_q;
  assign bus.wb_data_out = wdata_q;

`ifndef WB_MASTER_TIMEOUT_EN
  // Without the timeout feature the error flag never leaves its reset value.
  logic unused_err;
  assign unused_err = rsp_err_q;
`endif

endmodule

// File: tb/tb_wb_host_master.sv
// ---------------------------------------------------------------------------
// tb_wb_host_master
//   Directed self-checking bench for wb_host_master: reset values, write,
//   read, response backpressure, stray ACKs, timeout (or its absence when
//   WB_MASTER_TIMEOUT_EN is undefined) and reset in the middle of a cycle.
// ---------------------------------------------------------------------------
module tb_wb_host_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  logic clk;
  logic reset;

  int tests_run    = 0;
  int tests_failed = 0;

  wb_host_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  wb_host_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.master)
  );

  // 100 MHz-style clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a command and let it be accepted on the next edge.
  task automatic issue_cmd(input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = we;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_data  = data;
    bus_if.cmd_sel   = sel;
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic complete_rsp();
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if (bus_if.cmd_ready !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.rsp_valid !== 1'b0) begin
      $display("[TB] FAIL reset_handshake: cmd_ready=%b busy=%b rsp_valid=%b expected 1 0 0",
               bus_if.cmd_ready, bus_if.busy, bus_if.rsp_valid);
      tests_failed++;
    end
    tests_run++;
    if (bus_if.rsp_err !== 1'b0 || bus_if.rsp_data !== 32'h0) begin
      $display("[TB] FAIL reset_rsp: err=%b data=%h expected 0 00000000",
               bus_if.rsp_err, bus_if.rsp_data);
      tests_failed++;
    end
    tests_run++;
    if (bus_if.wb_cyc_out !== 1'b0 || bus_if.wb_stb_out !== 1'b0 || bus_if.wb_we_out !== 1'b0
        || bus_if.wb_sel_out !== 4'h0 || bus_if.wb_addr_out !== 32'h0
        || bus_if.wb_data_out !== 32'h0) begin
      $display("[TB] FAIL reset_wb: cyc=%b stb=%b we=%b sel=%h addr=%h dat=%h expected all 0",
               bus_if.wb_cyc_out, bus_if.wb_stb_out, bus_if.wb_we_out, bus_if.wb_sel_out,
               bus_if.wb_addr_out, bus_if.wb_data_out);
      tests_failed++;
    end
  endtask

  task automatic test_write();
    bus_if.wb_data_in = 32'hFFFF_FFFF;
    issue_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    // Scramble the command inputs; the latched bus values must not follow.
    bus_if.cmd_addr = 32'h0BAD_0BAD;
    bus_if.cmd_data = 32'h1111_2222;
    bus_if.cmd_sel  = 4'h1;
    bus_if.cmd_we   = 1'b0;
    tests_run++;
    if (bus_if.wb_cyc_out !== 1'b1 || bus_if.wb_stb_out !== 1'b1 || bus_if.busy !== 1'b1
        || bus_if.cmd_ready !== 1'b0) begin
      $display("[TB] FAIL write_start: cyc=%b stb=%b busy=%b cmd_ready=%b expected 1 1 1 0",
               bus_if.wb_cyc_out, bus_if.wb_stb_out, bus_if.busy, bus_if.cmd_ready);
      tests_failed++;
    end
    tick();
    tick();
    tests_run++;
    if (bus_if.wb_stb_out !== 1'b1 || bus_if.wb_we_out !== 1'b1 || bus_if.wb_addr_out !== 32'h3000_0004
        || bus_if.wb_data_out !== 32'hDEAD_BEEF || bus_if.wb_sel_out !== 4'hF) begin
      $display("[TB] FAIL write_hold: stb=%b we=%b addr=%h dat=%h sel=%h expected 1 1 30000004 deadbeef f",
               bus_if.wb_stb_out, bus_if.wb_we_out, bus_if.wb_addr_out, bus_if.wb_data_out,
               bus_if.wb_sel_out);
      tests_failed++;
    end
    bus_if.wb_ack_in = 1'b1;
    tick();
    bus_if.wb_ack_in = 1'b0;
    tests_run++;
    if (bus_if.wb_cyc_out !== 1'b0 || bus_if.wb_stb_out !== 1'b0 || bus_if.rsp_valid !== 1'b1
        || bus_if.rsp_data !== 32'h0 || bus_if.rsp_err !== 1'b0) begin
      $display("[TB] FAIL write_ack: cyc=%b stb=%b rsp_valid=%b data=%h err=%b expected 0 0 1 00000000 0",
               bus_if.wb_cyc_out, bus_if.wb_stb_out, bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_err);
      tests_failed++;
    end
    complete_rsp();
    tests_run++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.cmd_ready !== 1'b1 || bus_if.busy !== 1'b0) begin
      $display("[TB] FAIL write_done: rsp_valid=%b cmd_ready=%b busy=%b expected 0 1 0",
               bus_if.rsp_valid, bus_if.cmd_ready, bus_if.busy);
      tests_failed++;
    end
  endtask

  task automatic test_read();
    issue_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    tests_run++;
    if (bus_if.wb_cyc_out !== 1'b1 || bus_if.wb_we_out !== 1'b0 || bus_if.rsp_valid !== 1'b0) begin
      $display("[TB] FAIL read_start: cyc=%b we=%b rsp_valid=%b expected 1 0 0",
               bus_if.wb_cyc_out, bus_if.wb_we_out, bus_if.rsp_valid);
      tests_failed++;
    end
    bus_if.wb_ack_in  = 1'b1;
    bus_if.wb_data_in = 32'h1234_5678;
    tick();
    bus_if.wb_ack_in  = 1'b0;
    bus_if.wb_data_in = 32'h0;
    tests_run++;
    if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_data !== 32'h1234_5678 || bus_if.wb_cyc_out !== 1'b0) begin
      $display("[TB] FAIL read_rsp: rsp_valid=%b data=%h cyc=%b expected 1 12345678 0",
               bus_if.rsp_valid, bus_if.rsp_data, bus_if.wb_cyc_out);
      tests_failed++;
    end
    tests_run++;
    if (bus_if.wb_addr_out !== 32'h3000_0000 || bus_if.wb_we_out !== 1'b0) begin
      $display("[TB] FAIL read_addr_hold: addr=%h we=%b expected 30000000 0",
               bus_if.wb_addr_out, bus_if.wb_we_out);
      tests_failed++;
    end
    complete_rsp();
  endtask

  task automatic test_back_to_back();
    issue_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    bus_if.wb_ack_in  = 1'b1;
    bus_if.wb_data_in = 32'hA5A5_5A5A;
    tick();
    bus_if.wb_ack_in  = 1'b0;
    bus_if.wb_data_in = 32'h0;
    // Offer the next command while the response is still stalled.
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = 1'b1;
    bus_if.cmd_addr  = 32'h3000_000C;
    bus_if.cmd_data  = 32'h0102_0304;
    bus_if.cmd_sel   = 4'h3;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_data !== 32'hA5A5_5A5A || bus_if.cmd_ready !== 1'b0
          || bus_if.wb_cyc_out !== 1'b0) begin
        $display("[TB] FAIL backpressure_%0d: rsp_valid=%b data=%h cmd_ready=%b cyc=%b expected 1 a5a55a5a 0 0",
                 i, bus_if.rsp_valid, bus_if.rsp_data, bus_if.cmd_ready, bus_if.wb_cyc_out);
        tests_failed++;
      end
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    tests_run++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.cmd_ready !== 1'b1 || bus_if.wb_cyc_out !== 1'b0) begin
      $display("[TB] FAIL handshake_edge: rsp_valid=%b cmd_ready=%b cyc=%b expected 0 1 0",
               bus_if.rsp_valid, bus_if.cmd_ready, bus_if.wb_cyc_out);
      tests_failed++;
    end
    tick();
    bus_if.cmd_valid = 1'b0;
    tests_run++;
    if (bus_if.wb_cyc_out !== 1'b1 || bus_if.wb_addr_out !== 32'h3000_000C || bus_if.wb_sel_out !== 4'h3
        || bus_if.wb_data_out !== 32'h0102_0304) begin
      $display("[TB] FAIL next_cmd_start: cyc=%b addr=%h sel=%h dat=%h expected 1 3000000c 3 01020304",
               bus_if.wb_cyc_out, bus_if.wb_addr_out, bus_if.wb_sel_out, bus_if.wb_data_out);
      tests_failed++;
    end
    bus_if.wb_ack_in = 1'b1;
    tick();
    bus_if.wb_ack_in = 1'b0;
    complete_rsp();
  endtask

  task automatic test_stray_ack();
    issue_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    bus_if.wb_ack_in  = 1'b1;
    bus_if.wb_data_in = 32'hCAFE_F00D;
    tick();
    bus_if.wb_ack_in  = 1'b0;
    complete_rsp();
    // ACK while idle
    bus_if.wb_ack_in  = 1'b1;
    bus_if.wb_data_in = 32'h0000_0055;
    tick();
    bus_if.wb_ack_in  = 1'b0;
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.wb_cyc_out !== 1'b0 || bus_if.rsp_valid !== 1'b0
        || bus_if.rsp_data !== 32'hCAFE_F00D) begin
      $display("[TB] FAIL stray_idle: busy=%b cyc=%b rsp_valid=%b data=%h expected 0 0 0 cafef00d",
               bus_if.busy, bus_if.wb_cyc_out, bus_if.rsp_valid, bus_if.rsp_data);
      tests_failed++;
    end
    // ACK while holding a response
    issue_cmd(1'b0, 32'h3000_0018, 32'h0, 4'hF);
    bus_if.wb_ack_in  = 1'b1;
    bus_if.wb_data_in = 32'h600D_0001;
    tick();
    bus_if.wb_data_in = 32'h0000_0077;
    tick();
    bus_if.wb_ack_in  = 1'b0;
    tests_run++;
    if (bus_if.busy !== 1'b1 || bus_if.wb_cyc_out !== 1'b0 || bus_if.rsp_valid !== 1'b1
        || bus_if.rsp_data !== 32'h600D_0001) begin
      $display("[TB] FAIL stray_resp: busy=%b cyc=%b rsp_valid=%b data=%h expected 1 0 1 600d0001",
               bus_if.busy, bus_if.wb_cyc_out, bus_if.rsp_valid, bus_if.rsp_data);
      tests_failed++;
    end
    complete_rsp();
  endtask

`ifdef WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    issue_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bus_if.wb_stb_out !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin
        $display("[TB] FAIL timeout_stb_%0d: stb=%b rsp_valid=%b expected 1 0",
                 i, bus_if.wb_stb_out, bus_if.rsp_valid);
        tests_failed++;
      end
      tick();
    end
    tests_run++;
    if (bus_if.wb_stb_out !== 1'b0 || bus_if.wb_cyc_out !== 1'b0 || bus_if.rsp_valid !== 1'b1
        || bus_if.rsp_err !== 1'b1 || bus_if.rsp_data !== 32'h0) begin
      $display("[TB] FAIL timeout_abort: stb=%b cyc=%b rsp_valid=%b err=%b data=%h expected 0 0 1 1 00000000",
               bus_if.wb_stb_out, bus_if.wb_cyc_out, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_data);
      tests_failed++;
    end
    complete_rsp();
    // ACK exactly in the last allowed cycle wins over the abort.
    issue_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) tick();
    bus_if.wb_ack_in  = 1'b1;
    bus_if.wb_data_in = 32'h8765_4321;
    tick();
    bus_if.wb_ack_in  = 1'b0;
    tests_run++;
    if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_err !== 1'b0 || bus_if.rsp_data !== 32'h8765_4321) begin
      $display("[TB] FAIL timeout_ack_wins: rsp_valid=%b err=%b data=%h expected 1 0 87654321",
               bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_data);
      tests_failed++;
    end
    complete_rsp();
  endtask
`else
  task automatic test_no_timeout();
    issue_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) tick();
    tests_run++;
    if (bus_if.wb_stb_out !== 1'b1 || bus_if.rsp_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
      $display("[TB] FAIL no_timeout_wait: stb=%b rsp_valid=%b busy=%b expected 1 0 1",
               bus_if.wb_stb_out, bus_if.rsp_valid, bus_if.busy);
      tests_failed++;
    end
    bus_if.wb_ack_in  = 1'b1;
    bus_if.wb_data_in = 32'h8765_4321;
    tick();
    bus_if.wb_ack_in  = 1'b0;
    tests_run++;
    if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_err !== 1'b0 || bus_if.rsp_data !== 32'h8765_4321) begin
      $display("[TB] FAIL no_timeout_ack: rsp_valid=%b err=%b data=%h expected 1 0 87654321",
               bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_data);
      tests_failed++;
    end
    complete_rsp();
  endtask
`endif

  task automatic test_reset_mid_bus();
    issue_cmd(1'b1, 32'h3000_0030, 32'h5555_AAAA, 4'hC);
    tick();
    tests_run++;
    if (bus_if.wb_stb_out !== 1'b1) begin
      $display("[TB] FAIL midreset_pre: stb=%b expected 1", bus_if.wb_stb_out);
      tests_failed++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (bus_if.wb_cyc_out !== 1'b0 || bus_if.wb_stb_out !== 1'b0 || bus_if.rsp_valid !== 1'b0
        || bus_if.cmd_ready !== 1'b1 || bus_if.busy !== 1'b0) begin
      $display("[TB] FAIL midreset_post: cyc=%b stb=%b rsp_valid=%b cmd_ready=%b busy=%b expected 0 0 0 1 0",
               bus_if.wb_cyc_out, bus_if.wb_stb_out, bus_if.rsp_valid, bus_if.cmd_ready, bus_if.busy);
      tests_failed++;
    end
    // The master must be usable straight away.
    issue_cmd(1'b0, 32'h3000_0034, 32'h0, 4'hF);
    bus_if.wb_ack_in  = 1'b1;
    bus_if.wb_data_in = 32'h0BEE_F00D;
    tick();
    bus_if.wb_ack_in  = 1'b0;
    tests_run++;
    if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_data !== 32'h0BEE_F00D) begin
      $display("[TB] FAIL midreset_recover: rsp_valid=%b data=%h expected 1 0beef00d",
               bus_if.rsp_valid, bus_if.rsp_data);
      tests_failed++;
    end
    complete_rsp();
  endtask

  initial begin
    reset             = 1'b1;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_we     = 1'b0;
    bus_if.cmd_addr   = '0;
    bus_if.cmd_data   = '0;
    bus_if.cmd_sel    = '0;
    bus_if.rsp_ready  = 1'b0;
    bus_if.wb_ack_in  = 1'b0;
    bus_if.wb_data_in = '0;

    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_stray_ack();
`ifdef WB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_bus();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
